keypad_scanner: RTL

- Reads a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines.
- Debounces both press and release, then emits one registered 4-bit key code with a single-cycle valid strobe.
- It is the input-side counterpart of the multiplexed 7-segment display path: same active-low one-hot select style (1110, 1101, 1011, 0111).
- Its output feeds the digit/BCD registers that drive the display.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_sync2.sv | 25 ++
 rtl/keypad_scanner.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The auto-repeat feature of the scanner is enabled with KEYPAD_REPEAT_EN.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    HOLD     = 2'd3
  } state_t;

  // Active-low one-hot column drive, indexed by column number.
  localparam logic [3:0] COL_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } onehot_t;

  // valid=1 only when exactly one bit of v is low; idx is that bit's position.
  function automatic onehot_t onehot_low_idx(input logic [3:0] v);
    onehot_t r;
    r = '0;
    case (v)
      4'b1110: r = {1'b1, 2'd0};
      4'b1101: r = {1'b1, 2'd1};
      4'b1011: r = {1'b1, 2'd2};
      4'b0111: r = {1'b1, 2'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// Two-flop synchronizer for the asynchronous, pulled-up row lines.
module sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  // Idle (all released) value after reset so no phantom key is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 4'b1111;
      r_sync <= 4'b1111;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press and release debounce.
// Define KEYPAD_REPEAT_EN to re-pulse key_valid while a key stays held.
//
// Handshake: key_valid is a one-cycle strobe with no back-pressure; key_code
// is valid in that cycle and then holds until the next accepted press.
// key_pressed is a level covering the whole accepted hold.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed,
  output logic [1:0] dbg_state
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  generate
    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("keypad_scanner: parameter out of legal range");
    end
  endgenerate

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_row_idx;
  logic [1:0]    r_col_idx;
  logic [3:0]    w_row_s;
  logic [3:0]    w_pat;
  onehot_t       w_hit;
  logic          w_tick;
  logic          w_match;
  logic          w_released;
  logic          w_cnt_last;
  logic          w_advance;
  logic          w_latch;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_rep_fire;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (row),
    .o_q   (w_row_s)
  );

  assign w_hit      = onehot_low_idx(w_row_s);
  assign w_pat      = ~(4'b0001 << r_row_idx);
  assign w_tick     = (r_state == SCAN) && (r_div == DW'(SCAN_DIV - 1));
  assign w_match    = (w_row_s == w_pat);
  assign w_released = (w_row_s == 4'b1111);
  assign w_cnt_last = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Next-state and control decode; the shared counter serves press and release debounce.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    w_latch      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_tick) begin
          if (w_hit.valid) begin
            w_latch      = 1'b1;
            w_cnt_clr    = 1'b1;
            w_state_next = DEBOUNCE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (!w_match) begin
          w_state_next = SCAN;
          w_advance    = 1'b1;
          w_cnt_clr    = 1'b1;
        end else if (w_cnt_last) begin
          w_state_next = PRESSED;
          w_cnt_clr    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      PRESSED: begin
        w_state_next = HOLD;
        w_cnt_clr    = 1'b1;
      end
      HOLD: begin
        if (!w_released) begin
          w_cnt_clr = 1'b1;
        end else if (w_cnt_last) begin
          w_state_next = SCAN;
          w_advance    = 1'b1;
          w_cnt_clr    = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: begin
        w_state_next = SCAN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= SCAN;
    else       r_state <= w_state_next;
  end

  // Column dwell counter; runs only while scanning so each new column gets a full dwell.
  always_ff @(posedge clk) begin
    if (reset || r_state != SCAN || w_tick) r_div <= '0;
    else                                    r_div <= r_div + 1'b1;
  end

  // Column position and latched row of the candidate key.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_idx <= 2'd0;
      r_row_idx <= 2'd0;
    end else begin
      if (w_latch)   r_row_idx <= w_hit.idx;
      if (w_advance) r_col_idx <= r_col_idx + 2'd1;
    end
  end

  // Debounce / release counter.
  always_ff @(posedge clk) begin
    if (reset || w_cnt_clr) r_cnt <= '0;
    else if (w_cnt_inc)     r_cnt <= r_cnt + 1'b1;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] r_rep;
  logic          r_rep_armed;

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD, while the key is still down.
  always_comb begin
    w_rep_fire = 1'b0;
    if (r_state == HOLD && !w_released) begin
      if (r_rep_armed) w_rep_fire = (r_rep == RW'(REPEAT_PERIOD - 1));
      else             w_rep_fire = (r_rep == RW'(REPEAT_DELAY - 1));
    end
  end

  // Repeat timer; any released cycle restarts it from the initial delay.
  always_ff @(posedge clk) begin
    if (reset || r_state != HOLD || w_released) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_fire) begin
      r_rep       <= '0;
      r_rep_armed <= 1'b1;
    end else begin
      r_rep <= r_rep + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // Registered key outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= (r_state == PRESSED) || w_rep_fire;
      if (r_state == PRESSED) begin
        key_code    <= {r_row_idx, r_col_idx};
        key_pressed <= 1'b1;
      end else if (r_state == HOLD && w_advance) begin
        key_pressed <= 1'b0;
      end
    end
  end

  assign col       = COL_SEL[r_col_idx];
  assign dbg_state = r_state;

endmodule
